// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencing: stage valids, load-use stall, branch kill,
// operand-forwarding select and a saturating stall counter.

// Per-source forwarding select. It finds the youngest in-flight writer of
// src across EX/MEM/WB (index 0/1/2). It also reports an EX hit for the
// load-use check.
module pipe_hazard_src_sel (
  input  logic            [4:0] src,
  input  logic                  use_src,
  input  logic            [2:0] vld,
  input  logic [2:0]      [4:0] dest,
  input  logic            [2:0] we,
  output logic                  hit_ex,
  output logic            [1:0] sel
);
  logic [2:0] hit;

  // Stage match: a valid writer of a non-zero register equal to src
  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++)
      hit[i] = vld[i] & we[i] & (dest[i] != 5'd0) & (dest[i] == src);
  end

  assign hit_ex = hit[0];

  // Youngest producer wins: EX > MEM > WB, else regfile
  always_comb begin
    sel = 2'd0;
    if (use_src && src != 5'd0) begin
      if      (hit[0]) sel = 2'd1;
      else if (hit[1]) sel = 2'd2;
      else if (hit[2]) sel = 2'd3;
    end
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       id_rj,
  input  logic [4:0]       id_r2,
  input  logic             id_use_rj,
  input  logic             id_use_r2,
  input  logic [4:0]       id_dest,
  input  logic             id_gr_we,
  input  logic             id_is_load,
  input  logic             br_taken,
  output logic             valid_if,
  output logic             valid_id,
  output logic             valid_ex,
  output logic             valid_mem,
  output logic             valid_wb,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             br_commit,
  output logic [1:0]       fwd_rj,
  output logic [1:0]       fwd_r2,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int STAGES = 4;
  localparam int NSRC   = 2;

  // vld_pipe index: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB
  logic [STAGES:0]       vld_pipe;
  // Scoreboard index: 0 EX, 1 MEM, 2 WB
  logic [2:0][4:0]       sb_dest;
  logic [2:0]            sb_we;
  logic [2:0]            sb_load;

  logic [NSRC-1:0][4:0]  src;
  logic [NSRC-1:0]       src_use;
  logic [NSRC-1:0]       hit_ex;
  logic [NSRC-1:0][1:0]  sel;
  logic                  stall;

  assign src     = {id_r2, id_rj};
  assign src_use = {id_use_r2, id_use_rj};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    pipe_hazard_src_sel u_sel (
      .src     (src[g]),
      .use_src (src_use[g]),
      .vld     (vld_pipe[4:2]),
      .dest    (sb_dest),
      .we      (sb_we),
      .hit_ex  (hit_ex[g]),
      .sel     (sel[g])
    );
  end

  // A load in EX feeding ID cannot forward yet; hold IF/ID for one cycle.
  // The branch also waits, so it never resolves with stale operands.
  assign stall     = vld_pipe[1] & vld_pipe[2] & sb_load[0] & |(src_use & hit_ex);
  assign br_commit = br_taken & vld_pipe[1] & ~stall;
  assign if_id_en  = ~stall;
  assign id_ex_en  = 1'b1;
  assign fwd_rj    = sel[0];
  assign fwd_r2    = sel[1];

  assign valid_if  = vld_pipe[0];
  assign valid_id  = vld_pipe[1];
  assign valid_ex  = vld_pipe[2];
  assign valid_mem = vld_pipe[3];
  assign valid_wb  = vld_pipe[4];

  // Stage valids and scoreboard: MEM/WB always advance; on a stall, EX takes a bubble
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      sb_dest  <= '0;
      sb_we    <= '0;
      sb_load  <= '0;
    end else begin
      vld_pipe[4] <= vld_pipe[3];
      vld_pipe[3] <= vld_pipe[2];
      sb_dest[2]  <= sb_dest[1];
      sb_we[2]    <= sb_we[1];
      sb_load[2]  <= sb_load[1];
      sb_dest[1]  <= sb_dest[0];
      sb_we[1]    <= sb_we[0];
      sb_load[1]  <= sb_load[0];
      if (stall) begin
        vld_pipe[2] <= 1'b0;
        sb_dest[0]  <= 5'd0;
        sb_we[0]    <= 1'b0;
        sb_load[0]  <= 1'b0;
      end else begin
        vld_pipe[0] <= 1'b1;
        vld_pipe[1] <= vld_pipe[0] & ~br_commit;
        vld_pipe[2] <= vld_pipe[1];
        sb_dest[0]  <= id_dest;
        sb_we[0]    <= id_gr_we;
        sb_load[0]  <= id_is_load;
      end
    end
  end

  // Stall-cycle counter that sticks at all-ones
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                      stall_cnt <= '0;
    else if (stall && ~&stall_cnt)    stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: fill, forwarding, load-use, branch,
// r0, counter saturation (narrow instance) and asynchronous reset mid-stall.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] id_rj, id_r2, id_dest;
  logic       id_use_rj, id_use_r2, id_gr_we, id_is_load, br_taken;

  logic       valid_if, valid_id, valid_ex, valid_mem, valid_wb;
  logic       if_id_en, id_ex_en, br_commit;
  logic [1:0] fwd_rj, fwd_r2;
  logic [15:0] stall_cnt;

  logic       s_if, s_id, s_ex, s_mem, s_wb, s_ifen, s_idexen, s_brc;
  logic [1:0] s_fwd_rj, s_fwd_r2;
  logic [2:0] s_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .id_rj(id_rj), .id_r2(id_r2), .id_use_rj(id_use_rj), .id_use_r2(id_use_r2),
    .id_dest(id_dest), .id_gr_we(id_gr_we), .id_is_load(id_is_load),
    .br_taken(br_taken),
    .valid_if(valid_if), .valid_id(valid_id), .valid_ex(valid_ex),
    .valid_mem(valid_mem), .valid_wb(valid_wb),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .br_commit(br_commit),
    .fwd_rj(fwd_rj), .fwd_r2(fwd_r2), .stall_cnt(stall_cnt)
  );

  // Narrow counter copy so saturation is reachable in a few cycles
  pipe_hazard_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .resetn(resetn),
    .id_rj(id_rj), .id_r2(id_r2), .id_use_rj(id_use_rj), .id_use_r2(id_use_r2),
    .id_dest(id_dest), .id_gr_we(id_gr_we), .id_is_load(id_is_load),
    .br_taken(br_taken),
    .valid_if(s_if), .valid_id(s_id), .valid_ex(s_ex),
    .valid_mem(s_mem), .valid_wb(s_wb),
    .if_id_en(s_ifen), .id_ex_en(s_idexen), .br_commit(s_brc),
    .fwd_rj(s_fwd_rj), .fwd_r2(s_fwd_r2), .stall_cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Drive the ID-stage fields; settles 1 time unit before returning
  task automatic id_set(input logic [4:0] rj, input logic [4:0] r2, input logic urj,
                        input logic ur2, input logic [4:0] dst, input logic we,
                        input logic ld, input logic br);
    id_rj = rj; id_r2 = r2; id_use_rj = urj; id_use_r2 = ur2;
    id_dest = dst; id_gr_we = we; id_is_load = ld; br_taken = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_valids", {valid_if, valid_id, valid_ex, valid_mem, valid_wb}, 5'b00000);
    chk("rst_en",     {if_id_en, id_ex_en, br_commit}, 3'b110);
    chk("rst_fwd",    {fwd_rj, fwd_r2}, 4'b0000);
    chk("rst_cnt",    stall_cnt, 0);

    // Fill: IF valid after edge 1, WB valid after edge 5
    resetn = 1'b1;
    tick();
    chk("fill_e1", {valid_if, valid_id}, 2'b10);
    repeat (3) tick();
    chk("fill_e4_wb", valid_wb, 0);
    tick();
    chk("fill_e5_all", {valid_if, valid_id, valid_ex, valid_mem, valid_wb}, 5'b11111);
    chk("fill_fwd", {fwd_rj, fwd_r2}, 4'b0000);
    chk("fill_cnt", stall_cnt, 0);

    // ALU chain on r4: EX -> MEM -> WB -> regfile
    id_set(0, 0, 0, 0, 4, 1, 0, 0);
    tick();
    id_set(4, 0, 1, 0, 0, 0, 0, 0);
    chk("alu_ex_fwd", fwd_rj, 1);
    chk("alu_ex_nostall", if_id_en, 1);
    tick();
    chk("alu_mem_fwd", fwd_rj, 2);
    tick();
    chk("alu_wb_fwd", fwd_rj, 3);
    tick();
    chk("alu_rf_fwd", fwd_rj, 0);
    id_set(4, 0, 0, 0, 0, 0, 0, 0);

    // r7 written twice back to back: EX copy wins over MEM
    id_set(0, 0, 0, 0, 7, 1, 0, 0);
    tick();
    tick();
    id_set(0, 7, 0, 1, 0, 0, 0, 0);
    chk("ex_over_mem", fwd_r2, 1);
    id_set(0, 7, 0, 0, 0, 0, 0, 0);
    chk("unused_src", fwd_r2, 0);

    // ld.w r0 in EX, ID reading r0: never a hazard
    id_set(0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    id_set(0, 0, 1, 1, 0, 0, 0, 0);
    chk("r0_nostall", if_id_en, 1);
    chk("r0_fwd", {fwd_rj, fwd_r2}, 4'b0000);
    tick();

    // Load-use on r5 via r2
    id_set(0, 0, 0, 0, 5, 1, 1, 0);
    tick();
    id_set(0, 5, 0, 1, 0, 0, 0, 0);
    chk("lu_stall", if_id_en, 0);
    chk("lu_idex_en", id_ex_en, 1);
    tick();
    exp_cnt++;
    chk("lu_bubble", {valid_if, valid_id, valid_ex, valid_mem}, 4'b1101);
    chk("lu_cnt", stall_cnt, exp_cnt);
    chk("lu_after_nostall", if_id_en, 1);
    chk("lu_after_fwd", fwd_r2, 2);
    tick();

    // Taken branch kills the IF slot; ignored when ID is invalid
    id_set(0, 0, 0, 0, 0, 0, 0, 1);
    chk("br_commit", br_commit, 1);
    tick();
    chk("br_kill", {valid_if, valid_id}, 2'b10);
    chk("br_noid", br_commit, 0);
    tick();
    id_set(0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_refill", valid_id, 1);

    // Stall plus branch: bne reading r6 behind ld.w r6
    id_set(0, 0, 0, 0, 6, 1, 1, 0);
    tick();
    id_set(0, 6, 0, 1, 0, 0, 0, 1);
    chk("sb_stall_nocommit", {br_commit, if_id_en}, 2'b00);
    tick();
    exp_cnt++;
    chk("sb_commit", br_commit, 1);
    chk("sb_fwd", fwd_r2, 2);
    tick();
    chk("sb_kill", valid_id, 0);
    id_set(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Back-to-back dependent loads on r5: stall every other cycle
    id_set(5, 0, 1, 0, 5, 1, 1, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("chain_stall_%0d", i), if_id_en, (i % 2 == 1) ? 0 : 1);
      if (i % 2 == 1) exp_cnt++;
      tick();
    end
    chk("chain_cnt", stall_cnt, exp_cnt);
    chk("sat_cnt", s_cnt, 3'b111);
    tick();
    chk("sat_hold_pre", if_id_en, 0);
    tick();
    chk("sat_hold", s_cnt, 3'b111);

    // Async reset in the middle of a stall cycle
    tick();
    chk("mid_stall", if_id_en, 0);
    resetn = 1'b0;
    #1;
    chk("arst_valids", {valid_if, valid_id, valid_ex, valid_mem, valid_wb}, 5'b00000);
    chk("arst_cnt", stall_cnt, 0);
    chk("arst_en", if_id_en, 1);
    tick();
    resetn = 1'b1;
    tick();
    chk("arst_refill", {valid_if, valid_id, valid_ex}, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Sequencing controller for the five-stage LoongArch pipeline (IF/ID/EX/MEM/WB). It owns the per-stage valid bits, detects load-use hazards and stalls IF/ID while inserting an EX bubble, kills the wrong-path fetch on a taken branch resolved in ID, and selects operand-forwarding sources for ID. It keeps an internal destination scoreboard for EX/MEM/WB and a saturating stall counter for performance debug.

## Interface
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- id_rj  in  5  ID source register 1
- id_r2  in  5  ID source register 2 (rk, or rd for st/branches)
- id_use_rj  in  1  ID instruction reads id_rj
- id_use_r2  in  1  ID instruction reads id_r2
- id_dest  in  5  ID destination register
- id_gr_we  in  1  ID instruction writes GPR
- id_is_load  in  1  ID instruction is ld.w
- br_taken  in  1  branch/jump in ID resolves taken
- valid_if, valid_id, valid_ex, valid_mem, valid_wb  out  1 each  stage-valid bits
- if_id_en  out  1  load enable for IF/ID register and PC
- id_ex_en  out  1  load enable for ID/EX register
- br_commit  out  1  qualified taken branch; PC loads target
- fwd_rj, fwd_r2  out  2 each  source: 0 regfile, 1 EX, 2 MEM, 3 WB
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Scoreboard: registers {dest, we, load} for EX, MEM, WB. These registers shift with the stage valid bits. An entry matches source s when stage valid & we & dest != 0 & dest == s.
- Load-use stall: stall = valid_id & valid_ex & ex_load & ((id_use_rj & match_ex(id_rj)) | (id_use_r2 & match_ex(id_r2))).
- Forwarding (combinational):
  - If the source is unused or r0, select 0.
  - Otherwise select the first match in priority order EX(1) > MEM(2) > WB(3); select 0 if there is no match.
  - An EX match is never a load while stall is low.
- br_commit = br_taken & valid_id & ~stall. Stall has priority: the branch waits for its operands.
- Normal advance (no stall): valid_if<=1, valid_id<=valid_if & ~br_commit, valid_ex<=valid_id, valid_mem<=valid_ex, valid_wb<=valid_mem. The scoreboard shifts and the EX entry is loaded from id_*.
- Stall cycle:
  - valid_if and valid_id hold.
  - valid_ex<=0 (bubble); the EX scoreboard entry is cleared (we=0, load=0).
  - MEM and WB advance.
  - if_id_en=0, id_ex_en=1 (the bubble is loaded).
- if_id_en = ~stall, id_ex_en = 1.
- stall_cnt increments on each stall cycle and saturates at all-ones.

## Timing
- Reset (resetn low, asynchronous): all valid bits 0, scoreboard cleared, stall_cnt 0.
- Reset outputs: if_id_en=1, id_ex_en=1, br_commit=0, fwd_*=0.
- First cycle after release: valid_if becomes 1 on the first clk edge. valid_wb first rises 4 edges later.
- stall, br_commit and fwd_* are same-cycle combinational from registered state and inputs. Valid and scoreboard updates take effect on the next edge.
- Load-use penalty is exactly 1 cycle. After the bubble the load is in MEM, and the consumer gets fwd=2.
- Taken-branch penalty is exactly 1 killed slot (the IF instruction).
- Boundary conditions:
  - br_taken with valid_id=0 is ignored.
  - Stall plus br_taken in the same cycle: no commit; the branch commits in the following cycle.
  - Dest r0 never matches.
  - Same register written in both EX and MEM: EX wins.
  - resetn asserted mid-stall: all state clears immediately; no hold is remembered.
  - stall_cnt at all-ones stays at all-ones.

## Test plan
- Reset/fill: hold resetn low 3 cycles, then release with no hazards -> outputs at reset values; valid_if=1 after edge 1, valid_wb=1 after edge 5; fwd=0; stall_cnt=0.
- ALU chain: EX holds add.w r4 (we=1), ID reads rj=r4 -> fwd_rj=1, no stall. Next cycle MEM holds r4 -> fwd_rj=2. Following cycle -> fwd_rj=3.
- Load-use: ld.w r5 in EX, ID reads r2=r5 with id_use_r2=1 -> stall=1, if_id_en=0, next valid_ex=0, stall_cnt=1. Next cycle stall=0 and fwd_r2=2.
- Taken branch: valid_id=1, br_taken=1, no stall -> br_commit=1 and next valid_id=0. With valid_id=0 the same br_taken gives br_commit=0.
- Stall plus branch: bne reading r6 while ld.w r6 is in EX with br_taken=1 -> br_commit=0 in the stall cycle, br_commit=1 in the next cycle with fwd_r2=2.
- r0 and saturation:
  - ld.w r0 in EX with ID reading r0 -> no stall, fwd=0.
  - Force stall_cnt to all-ones then stall again -> stall_cnt remains 16'hFFFF.
  - Assert resetn low mid-stall -> all valid bits 0 asynchronously.
